// File: rtl/ecc_enc_top_if.sv
// Data/codeword bundle between a cache write path (master) and the SEC-DED encoder (slave).
interface ecc_enc_if;
    logic [63:0] data_i;
    logic [71:0] code_o;

    modport master (output data_i, input code_o);
    modport slave  (input data_i, output code_o);
endinterface

// File: rtl/ecc_enc_top.sv
// SEC-DED (72,64) Hamming encoder: data in the low 64 bits, 7 Hamming bits plus overall parity above,
// registered with one cycle of latency.
module ecc_enc_top (
    input  logic       clk,
    input  logic       rst,
    ecc_enc_if.slave   bus
);

    logic [6:0]  hamD;
    logic [71:0] codeD;
    logic [71:0] codeQ;

    // Data bit k sits at the k-th Hamming position that is not a power of two, starting at 3.
    // Stepping past a power of two only ever needs one extra increment because powers of two above 2 are never adjacent.
    function automatic logic [6:0] hammingBits(input logic [63:0] d);
        logic [6:0] c;
        int         pos;
        c   = '0;
        pos = 2;
        for (int k = 0; k < 64; k++) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) begin
                pos = pos + 1;
            end
            for (int i = 0; i < 7; i++) begin
                if (pos[i]) begin
                    c[i] = c[i] ^ d[k];
                end
            end
        end
        return c;
    endfunction

    always_comb begin
        hamD  = hammingBits(bus.data_i);
        codeD = {^{hamD, bus.data_i}, hamD, bus.data_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codeQ <= '0;
        end else begin
            codeQ <= codeD;
        end
    end

    assign bus.code_o = codeQ;

endmodule

// File: tb/tb_ecc_enc_top.sv
// Self-checking bench for ecc_enc_top: driver pushes expected codewords, a negedge monitor pops and compares.
module tb_ecc_enc_top;

    logic clk = 1'b0;
    logic rst;

    ecc_enc_if bus ();

    ecc_enc_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    int          posOf[64];
    logic [71:0] expQ[$];
    logic [71:0] seenQ[$];

    // Reference: the Hamming syndrome of a word is the XOR of the positions of its set data bits.
    function automatic logic [71:0] refEncode(input logic [63:0] d);
        int         syn;
        logic [6:0] ham;
        syn = 0;
        for (int k = 0; k < 64; k++) begin
            if (d[k]) syn = syn ^ posOf[k];
        end
        ham = syn[6:0];
        return {(^d) ^ (^ham), ham, d};
    endfunction

    function automatic void refDecode(input logic [71:0] code, output logic [63:0] data, output logic dbl);
        int syn;
        syn = 0;
        for (int k = 0; k < 64; k++) begin
            if (code[k]) syn = syn ^ posOf[k];
        end
        for (int i = 0; i < 7; i++) begin
            if (code[64+i]) syn = syn ^ (1 << i);
        end
        data = code[63:0];
        dbl  = 1'b0;
        if (^code) begin
            for (int k = 0; k < 64; k++) begin
                if (posOf[k] == syn) data[k] = ~data[k];
            end
        end else if (syn != 0) begin
            dbl = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] d);
        @(negedge clk);
        bus.data_i = d;
        @(posedge clk);
        if (!rst) expQ.push_back(refEncode(d));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("drainEmpty", 72'(expQ.size()), 72'd0);
    endtask

    initial begin : monitor
        logic [71:0] exp;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                checkOutput("encode", bus.code_o, exp);
                checkOutput("evenParity", {71'd0, ^bus.code_o}, 72'd0);
                seenQ.push_back(bus.code_o);
            end
        end
    end

    initial begin : watchdog
        #300000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : stimulus
        int          p;
        int          badSyn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] words[4];
        logic [63:0] decData;
        logic        decDbl;
        logic [71:0] flipped;
        int          b1;
        int          b2;

        // Hamming positions 1..71 that are not powers of two, in ascending order.
        p = 0;
        for (int pos = 1; pos < 72; pos++) begin
            if ($countones(pos) != 1) begin
                posOf[p] = pos;
                p++;
            end
        end

        rst        = 1'b1;
        bus.data_i = 64'h0123_4567_89AB_CDEF;
        #12;
        checkOutput("resetState", bus.code_o, 72'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] single-bit walk");
        for (int k = 0; k < 64; k++) applyStimulus(64'h1 << k);
        drain();
        checkOutput("walkSyn0",  72'(seenQ[0][71:64]),  72'h83);
        checkOutput("walkSyn1",  72'(seenQ[1][71:64]),  72'h85);
        checkOutput("walkSyn3",  72'(seenQ[3][71:64]),  72'h07);
        checkOutput("walkSyn4",  72'(seenQ[4][71:64]),  72'h89);
        checkOutput("walkSyn63", 72'(seenQ[63][71:64]), 72'hC7);
        badSyn = 0;
        for (int i = 0; i < 64; i++) begin
            if (seenQ[i][71:64] == 8'h00) badSyn++;
            for (int j = i + 1; j < 64; j++) begin
                if (seenQ[i][71:64] == seenQ[j][71:64]) badSyn++;
            end
        end
        checkOutput("walkDistinctNonzero", 72'(badSyn), 72'd0);
        seenQ.delete();

        $display("[TB] zero and linearity");
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        applyStimulus(64'h0);
        applyStimulus(64'h3);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(a ^ b);
        drain();
        checkOutput("zeroWord", seenQ[0], 72'h0);
        checkOutput("syn3", 72'(seenQ[1][71:64]), 72'h06);
        checkOutput("linearity", 72'(seenQ[4][71:64]), 72'(seenQ[2][71:64] ^ seenQ[3][71:64]));
        seenQ.delete();

        $display("[TB] random back-to-back stream");
        for (int i = 0; i < 1000; i++) applyStimulus({$urandom, $urandom});
        drain();
        seenQ.delete();

        $display("[TB] asynchronous reset");
        applyStimulus(64'hDEAD_BEEF_CAFE_F00D);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", bus.code_o, 72'h0);
        bus.data_i = {$urandom, $urandom};
        @(posedge clk);
        #1;
        checkOutput("resetHold1", bus.code_o, 72'h0);
        @(posedge clk);
        #1;
        checkOutput("resetHold2", bus.code_o, 72'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        expQ.push_back(refEncode(bus.data_i));
        drain();
        seenQ.delete();

        $display("[TB] decoder loopback");
        for (int w = 0; w < 4; w++) begin
            words[w] = {$urandom, $urandom};
            applyStimulus(words[w]);
        end
        drain();
        for (int w = 0; w < 4; w++) begin
            for (int bit_ = 0; bit_ < 72; bit_++) begin
                flipped       = seenQ[w];
                flipped[bit_] = ~flipped[bit_];
                refDecode(flipped, decData, decDbl);
                checkOutput("singleCorrect", {7'd0, decDbl, decData}, {8'd0, words[w]});
            end
            for (int t = 0; t < 20; t++) begin
                b1 = $urandom_range(71, 0);
                b2 = (b1 + $urandom_range(71, 1)) % 72;
                flipped     = seenQ[w];
                flipped[b1] = ~flipped[b1];
                flipped[b2] = ~flipped[b2];
                refDecode(flipped, decData, decDbl);
                checkOutput("doubleDetect", {71'd0, decDbl}, 72'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ecc_enc_top.md
# ecc_enc_top

SEC-DED (72,64) Hamming encoder for cache data arrays. It takes a 64-bit data word and appends 8 check bits (7 Hamming bits plus 1 overall parity bit), producing a 72-bit codeword for storage. The matching decoder uses this codeword to correct single-bit errors and detect double-bit errors. The output is registered: one clock cycle of latency, asynchronous active-high reset.

## Interface
- No parameters. Data width 64 and check width 8 are fixed.
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset, asynchronous and active-high; clears the output register.
- IN   input  64  data word to encode; sampled on each rising CLK edge.
- OUT  output 72  registered codeword.
  - OUT[63:0] = data as sampled.
  - OUT[71:64] = check byte (SYN).

## Operation
- Position map: Hamming positions 1..71, excluding the power-of-two positions 1, 2, 4, 8, 16, 32 and 64, leave exactly 64 data positions.
- IN[k] occupies the k-th non-power-of-two position, in ascending order.
  - IN[0]→3, IN[1]→5, IN[2]→6, IN[3]→7, IN[4]→9, …, IN[56]→63, IN[57]→65, …, IN[63]→71.
- Check bits c[i], i=0..6: XOR of every IN[k] whose position has bit i set.
- Overall parity c[7]: XOR of all 64 data bits and c[0..6], giving even parity over the 72 bits.
- OUT[63:0] = IN. OUT[64+i] = c[i] for i=0..7.
- The encode path is purely combinational XOR trees into a 72-bit register. There is no handshake; a new word is accepted every cycle.
- Linearity: the check byte of A^B equals check(A)^check(B). The all-zero word encodes to all-zero.

## Timing
- Latency is 1 cycle. IN sampled at edge n appears on OUT after edge n and holds until edge n+1.
- Throughput is one word per cycle. Back-to-back changes on IN every cycle are encoded independently.
- RST asserted, at any time including mid-stream: OUT goes to 72'h0 immediately, without waiting for a clock edge. 72'h0 is the valid codeword for data 0.
- While RST is held high, OUT stays 0 and clock edges are ignored.
- After RST is released, the first rising edge captures IN normally.
- There is no X-propagation masking. An X on IN appears on OUT after the next edge.

## Test plan
- Single-bit walk:
  - IN = 1<<k for k=0..63, one per cycle; each OUT[71:64] must match the column computed from the position map.
  - IN=64'h1 → SYN=8'h83.
  - IN=64'h2 → SYN=8'h85.
  - IN=64'h8 → SYN=8'h07.
  - IN=64'h10 → SYN=8'h89.
  - IN=64'h8000_0000_0000_0000 → SYN=8'hC7.
  - All 64 SYN values must be distinct and nonzero.
- Zero and linearity:
  - IN=0 → OUT=72'h0.
  - IN=64'h3 → SYN=8'h83^8'h85=8'h06.
  - Random A, B: SYN(A^B)=SYN(A)^SYN(B).
- Parity property: for 1000 random IN, the XOR-reduction of OUT[71:0] is 0, and OUT[63:0] equals the IN sampled one cycle earlier.
- Latency and pipelining: change IN every cycle; OUT tracks with exactly one cycle of delay and nothing is dropped.
- Reset:
  - Assert RST between clock edges while OUT is nonzero → OUT=0 before the next edge.
  - Hold RST high across edges → OUT stays 0.
  - Deassert RST → the next edge loads the encoding of IN.
- Decoder loopback: feed OUT to the decoder, flipping any one bit → corrected data equals IN. Flipping any two bits → double-error flag raised.
